// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, load-type encoding and stall bit index.
package core_pkg;

  localparam int CORE_XLEN    = 32;
  localparam int CORE_RADDR_W = 6;

  // Bit of busStall that freezes the MEM/WB boundary.
  localparam int MEM_STALL_BIT = 1;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LW   = 3'b001,
    LD_LH   = 3'b010,
    LD_LB   = 3'b011,
    LD_LHU  = 3'b100,
    LD_LBU  = 3'b101,
    LD_FLW  = 3'b110,
    LD_RSVD = 3'b111
  } load_t;

  // The reserved encoding behaves exactly like "no load".
  function automatic logic is_load_valid(input logic [2:0] ld_type);
    return (ld_type != LD_NONE) && (ld_type != LD_RSVD);
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: shifts the addressed bytes to the bottom of the word and
// sign/zero-extends them according to the load type.
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      ld_type,
  output logic [XLEN-1:0] data
);

  // Bytes beyond the top of the word shift in as zero, which gives the
  // zero-filled behaviour for misaligned word and halfword accesses.
  logic [XLEN-1:0] shifted;
  assign shifted = word >> {offset, 3'b000};

  // Select and extend the addressed field.
  always_comb begin
    data = '0;
    case (ld_type)
      LD_LW, LD_FLW: data = shifted;
      // A halfword straddling a byte boundary is returned unextended.
      LD_LH: data = offset[0] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                              : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LD_LHU: data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LD_LB:  data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LD_LBU: data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline stage: captures load data across bus stalls, aligns it and
// registers the writeback bundle for the register files and forwarding muxes.
module mem_wb
  import core_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int RADDR_W = CORE_RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         busStall,
  input  logic [XLEN-1:0]    alu_out_MEM,
  input  logic [RADDR_W-1:0] rd_addr_MEM,
  input  logic               wb_en_MEM,
  input  logic               fwb_en_MEM,
  input  logic [2:0]         is_load_MEM,
  input  logic [XLEN-1:0]    DM_DO,
  output logic [XLEN-1:0]    fw_from_MEM,
  output logic [XLEN-1:0]    fw_from_WB,
  output logic [XLEN-1:0]    rd_data_WB,
  output logic [RADDR_W-1:0] rd_addr_WB,
  output logic               wb_en_WB,
  output logic               fwb_en_WB
);

  logic            stall;
  logic            unused_stall_bit0;
  logic            load_valid;
  logic [XLEN-1:0] load_src;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] ld_hold_reg;
  logic            hold_v_reg;
  logic [XLEN-1:0] rd_data_reg;
  logic            int_wr_ok;

  assign stall             = busStall[MEM_STALL_BIT];
  assign unused_stall_bit0 = busStall[0];
  assign load_valid        = is_load_valid(is_load_MEM);

  // The SRAM output is only valid in the first MEM cycle; afterwards the held copy wins.
  assign load_src = hold_v_reg ? ld_hold_reg : DM_DO;

  load_align #(.XLEN(XLEN)) u_load_align (
    .word    (load_src),
    .offset  (alu_out_MEM[1:0]),
    .ld_type (is_load_MEM),
    .data    (load_data)
  );

  // x0 is hard-wired zero, and an FP write never also writes the integer file.
  assign int_wr_ok = wb_en_MEM && !fwb_en_MEM && (rd_addr_MEM != '0);

  // Capture load data on the first stalled cycle; drop it once the stall releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_hold_reg <= '0;
      hold_v_reg  <= 1'b0;
    end else if (stall) begin
      if (load_valid && !hold_v_reg) begin
        ld_hold_reg <= DM_DO;
        hold_v_reg  <= 1'b1;
      end
    end else begin
      hold_v_reg <= 1'b0;
    end
  end

  // Writeback register: frozen while stalled, otherwise takes the MEM bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
      rd_addr_WB  <= '0;
      wb_en_WB    <= 1'b0;
      fwb_en_WB   <= 1'b0;
    end else if (!stall) begin
      rd_data_reg <= load_valid ? load_data : alu_out_MEM;
      rd_addr_WB  <= rd_addr_MEM;
      wb_en_WB    <= int_wr_ok;
      fwb_en_WB   <= fwb_en_MEM;
    end
  end

  assign fw_from_MEM = alu_out_MEM;
  assign fw_from_WB  = rd_data_reg;
  assign rd_data_WB  = rd_data_reg;

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed vector table, stall/reset sequences
// and randomized traffic against a byte-level reference model.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  busStall;
  logic [31:0] alu_out_MEM;
  logic [5:0]  rd_addr_MEM;
  logic        wb_en_MEM;
  logic        fwb_en_MEM;
  logic [2:0]  is_load_MEM;
  logic [31:0] DM_DO;
  logic [31:0] fw_from_MEM;
  logic [31:0] fw_from_WB;
  logic [31:0] rd_data_WB;
  logic [5:0]  rd_addr_WB;
  logic        wb_en_WB;
  logic        fwb_en_WB;

  int checks = 0;
  int errors = 0;

  // Reference model state (expected WB outputs and held load word).
  logic [31:0] m_data;
  logic [5:0]  m_rd;
  logic        m_wb;
  logic        m_fwb;
  logic        m_hold_v;
  logic [31:0] m_hold;

  typedef struct {
    logic [31:0] alu;
    logic [5:0]  rd;
    logic        wb;
    logic        fwb;
    logic [2:0]  ld;
    logic [31:0] dm;
    logic [31:0] e_data;
    logic [5:0]  e_rd;
    logic        e_wb;
    logic        e_fwb;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  mem_wb dut (
    .clk         (clk),
    .rst         (rst),
    .busStall    (busStall),
    .alu_out_MEM (alu_out_MEM),
    .rd_addr_MEM (rd_addr_MEM),
    .wb_en_MEM   (wb_en_MEM),
    .fwb_en_MEM  (fwb_en_MEM),
    .is_load_MEM (is_load_MEM),
    .DM_DO       (DM_DO),
    .fw_from_MEM (fw_from_MEM),
    .fw_from_WB  (fw_from_WB),
    .rd_data_WB  (rd_data_WB),
    .rd_addr_WB  (rd_addr_WB),
    .wb_en_WB    (wb_en_WB),
    .fwb_en_WB   (fwb_en_WB)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-array view of the load rules: bytes at offset o and above move down,
  // bytes past the top of the word read as zero.
  function automatic logic [31:0] ref_extract(input logic [31:0] w, input logic [1:0] o,
                                              input logic [2:0] t);
    logic [7:0] sb[4];
    for (int i = 0; i < 4; i++)
      sb[i] = (i + int'(o) < 4) ? w[8*(i+int'(o)) +: 8] : 8'h00;
    case (t)
      3'd1, 3'd6: return {sb[3], sb[2], sb[1], sb[0]};
      3'd2: return o[0] ? {16'h0000, sb[1], sb[0]} : {{16{sb[1][7]}}, sb[1], sb[0]};
      3'd4: return {16'h0000, sb[1], sb[0]};
      3'd3: return {{24{sb[0][7]}}, sb[0]};
      3'd5: return {24'h000000, sb[0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_is_load(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd6);
  endfunction

  task automatic model_reset();
    m_data = '0; m_rd = '0; m_wb = 1'b0; m_fwb = 1'b0; m_hold_v = 1'b0; m_hold = '0;
  endtask

  // Apply the clock-edge rules to the model using the inputs present at the edge.
  task automatic model_edge();
    logic [31:0] src;
    src = m_hold_v ? m_hold : DM_DO;
    if (!busStall[1]) begin
      m_data = ref_is_load(is_load_MEM) ? ref_extract(src, alu_out_MEM[1:0], is_load_MEM)
                                        : alu_out_MEM;
      m_rd   = rd_addr_MEM;
      m_fwb  = fwb_en_MEM;
      m_wb   = wb_en_MEM && !fwb_en_MEM && (rd_addr_MEM != 6'd0);
      m_hold_v = 1'b0;
    end else if (ref_is_load(is_load_MEM) && !m_hold_v) begin
      m_hold   = DM_DO;
      m_hold_v = 1'b1;
    end
  endtask

  // One clock: verify the zero-latency forward, step the edge, compare with the model.
  task automatic cycle(input string tag);
    #1;
    check({tag, ".fw_from_MEM"}, fw_from_MEM, alu_out_MEM);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".rd_data_WB"}, rd_data_WB, m_data);
    check({tag, ".fw_from_WB"}, fw_from_WB, m_data);
    check({tag, ".rd_addr_WB"}, 32'(rd_addr_WB), 32'(m_rd));
    check({tag, ".wb_en_WB"}, 32'(wb_en_WB), 32'(m_wb));
    check({tag, ".fwb_en_WB"}, 32'(fwb_en_WB), 32'(m_fwb));
    $display("%s: stall=%b ld=%0d alu=%h dm=%h -> data=%h rd=%0d wb=%b fwb=%b",
             tag, busStall[1], is_load_MEM, alu_out_MEM, DM_DO,
             rd_data_WB, rd_addr_WB, wb_en_WB, fwb_en_WB);
  endtask

  task automatic set_mem(input logic [31:0] alu, input logic [5:0] rd, input logic wb,
                         input logic fwb, input logic [2:0] ld, input logic [31:0] dm);
    alu_out_MEM = alu; rd_addr_MEM = rd; wb_en_MEM = wb; fwb_en_MEM = fwb;
    is_load_MEM = ld; DM_DO = dm;
  endtask

  initial begin
    logic prev_stall;
    logic [31:0] r;

    //          alu           rd     wb    fwb   ld    dm             e_data         e_rd   e_wb  e_fwb
    vecs[0]  = '{32'h0000_0002, 6'd5,  1'b1, 1'b0, 3'd3, 32'h80FF_7F01, 32'hFFFF_FFFF, 6'd5,  1'b1, 1'b0};
    vecs[1]  = '{32'h0000_0002, 6'd4,  1'b1, 1'b0, 3'd4, 32'h8001_1234, 32'h0000_8001, 6'd4,  1'b1, 1'b0};
    vecs[2]  = '{32'h1234_5678, 6'd0,  1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'h1234_5678, 6'd0,  1'b0, 1'b0};
    vecs[3]  = '{32'h1234_5678, 6'd7,  1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'h1234_5678, 6'd7,  1'b1, 1'b0};
    vecs[4]  = '{32'h0000_0200, 6'd33, 1'b1, 1'b1, 3'd6, 32'h3F80_0000, 32'h3F80_0000, 6'd33, 1'b0, 1'b1};
    vecs[5]  = '{32'h0000_0010, 6'd2,  1'b1, 1'b0, 3'd2, 32'h0000_8765, 32'hFFFF_8765, 6'd2,  1'b1, 1'b0};
    vecs[6]  = '{32'h0000_0021, 6'd8,  1'b1, 1'b0, 3'd1, 32'h1122_3344, 32'h0011_2233, 6'd8,  1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0023, 6'd9,  1'b1, 1'b0, 3'd2, 32'hAABB_CCDD, 32'h0000_00AA, 6'd9,  1'b1, 1'b0};
    vecs[8]  = '{32'h0000_0021, 6'd10, 1'b1, 1'b0, 3'd2, 32'hAABB_CCDD, 32'h0000_BBCC, 6'd10, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_0003, 6'd11, 1'b1, 1'b0, 3'd5, 32'h80FF_7F01, 32'h0000_0080, 6'd11, 1'b1, 1'b0};
    vecs[10] = '{32'h0000_0000, 6'd12, 1'b1, 1'b0, 3'd3, 32'h80FF_7F81, 32'hFFFF_FF81, 6'd12, 1'b1, 1'b0};
    vecs[11] = '{32'hCAFE_BABE, 6'd13, 1'b1, 1'b0, 3'd7, 32'h0000_0000, 32'hCAFE_BABE, 6'd13, 1'b1, 1'b0};
    vecs[12] = '{32'h0000_0004, 6'd32, 1'b0, 1'b1, 3'd6, 32'h4000_0000, 32'h4000_0000, 6'd32, 1'b0, 1'b1};
    vecs[13] = '{32'h0000_0002, 6'd14, 1'b1, 1'b0, 3'd2, 32'h7FFF_0000, 32'h0000_7FFF, 6'd14, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    busStall = 2'b00;
    set_mem(32'h0, 6'd0, 1'b0, 1'b0, 3'd0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.rd_data_WB", rd_data_WB, 32'h0);
    check("reset.fw_from_WB", fw_from_WB, 32'h0);
    check("reset.rd_addr_WB", 32'(rd_addr_WB), 32'h0);
    check("reset.wb_en_WB", 32'(wb_en_WB), 32'h0);
    check("reset.fwb_en_WB", 32'(fwb_en_WB), 32'h0);
    rst = 1'b0;

    // Directed vector table, applied back to back without stalls
    for (int i = 0; i < NVEC; i++) begin
      set_mem(vecs[i].alu, vecs[i].rd, vecs[i].wb, vecs[i].fwb, vecs[i].ld, vecs[i].dm);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_data", i), rd_data_WB, vecs[i].e_data);
      check($sformatf("vec%0d.tbl_rd", i), 32'(rd_addr_WB), 32'(vecs[i].e_rd));
      check($sformatf("vec%0d.tbl_wb", i), 32'(wb_en_WB), 32'(vecs[i].e_wb));
      check($sformatf("vec%0d.tbl_fwb", i), 32'(fwb_en_WB), 32'(vecs[i].e_fwb));
    end

    // Stall hold: data present only in the first stalled cycle must survive the stall
    set_mem(32'h0000_0100, 6'd3, 1'b1, 1'b0, 3'd1, 32'hDEAD_BEEF);
    busStall = 2'b10;
    cycle("stall1");
    check("stall1.held_data", rd_data_WB, vecs[NVEC-1].e_data);
    check("stall1.held_rd", 32'(rd_addr_WB), 32'(vecs[NVEC-1].e_rd));
    DM_DO = 32'h0000_0000;
    cycle("stall2");
    check("stall2.held_data", rd_data_WB, vecs[NVEC-1].e_data);
    cycle("stall3");
    check("stall3.held_data", rd_data_WB, vecs[NVEC-1].e_data);
    busStall = 2'b00;
    cycle("release");
    check("release.data", rd_data_WB, 32'hDEAD_BEEF);
    check("release.rd", 32'(rd_addr_WB), 32'd3);
    check("release.wb", 32'(wb_en_WB), 32'd1);

    // Reset in the middle of a stalled load discards the held word
    set_mem(32'h0000_0300, 6'd15, 1'b1, 1'b0, 3'd1, 32'h55AA_55AA);
    busStall = 2'b10;
    cycle("rststall");
    DM_DO = 32'h1111_1111;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst.rd_data_WB", rd_data_WB, 32'h0);
    check("async_rst.fw_from_WB", fw_from_WB, 32'h0);
    check("async_rst.rd_addr_WB", 32'(rd_addr_WB), 32'h0);
    check("async_rst.wb_en_WB", 32'(wb_en_WB), 32'h0);
    check("async_rst.fwb_en_WB", 32'(fwb_en_WB), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    busStall = 2'b00;
    cycle("post_rst");
    check("post_rst.from_dm", rd_data_WB, 32'h1111_1111);

    // Randomized traffic; MEM inputs stay put while the stage is stalled
    prev_stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!prev_stall) begin
        r = $urandom;
        set_mem($urandom, r[5:0], r[6], r[7] & r[8], 3'($urandom_range(0, 7)), $urandom);
      end else begin
        DM_DO = $urandom;
      end
      r = $urandom;
      busStall = {r[1:0] == 2'b00, r[2]};
      cycle($sformatf("rand%0d", i));
      prev_stall = busStall[1];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
